// File: rtl/program_encoder_pkg.sv
// Shared RV32I encoding definitions: descriptor ops, opcode/funct fields,
// encoder FSM states and the pure descriptor-to-word encoding function.
package program_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_SLL, OP_SLLI, OP_SRL, OP_SRLI,
    OP_SRA, OP_SRAI, OP_XOR, OP_XORI, OP_OR, OP_ORI, OP_AND, OP_ANDI,
    OP_LW, OP_SW, OP_BEQ
  } instr_op_type;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} enc_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  function automatic logic op_is_defined(input instr_op_type op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_SLL, OP_SLLI, OP_SRL, OP_SRLI,
      OP_SRA, OP_SRAI, OP_XOR, OP_XORI, OP_OR, OP_ORI, OP_AND, OP_ANDI,
      OP_LW, OP_SW, OP_BEQ: op_is_defined = 1'b1;
      default:              op_is_defined = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode_instruction(
    input instr_op_type op,
    input logic [4:0]   rd,
    input logic [4:0]   rs1,
    input logic [4:0]   rs2,
    input logic [31:0]  imm
  );
    case (op)
      OP_ADD:  encode_instruction = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_SUB:  encode_instruction = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_SLL:  encode_instruction = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
      OP_SRL:  encode_instruction = {F7_BASE, rs2, rs1, F3_SR,  rd, OPC_OP};
      OP_SRA:  encode_instruction = {F7_ALT,  rs2, rs1, F3_SR,  rd, OPC_OP};
      OP_XOR:  encode_instruction = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_OP};
      OP_OR:   encode_instruction = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
      OP_AND:  encode_instruction = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
      OP_ADDI: encode_instruction = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
      OP_XORI: encode_instruction = {imm[11:0], rs1, F3_XOR, rd, OPC_OP_IMM};
      OP_ORI:  encode_instruction = {imm[11:0], rs1, F3_OR,  rd, OPC_OP_IMM};
      OP_ANDI: encode_instruction = {imm[11:0], rs1, F3_AND, rd, OPC_OP_IMM};
      OP_LW:   encode_instruction = {imm[11:0], rs1, F3_LW,  rd, OPC_LOAD};
      OP_SLLI: encode_instruction = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_OP_IMM};
      OP_SRLI: encode_instruction = {F7_BASE, imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
      OP_SRAI: encode_instruction = {F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
      OP_LUI:  encode_instruction = {imm[31:12], rd, OPC_LUI};
      OP_SW:   encode_instruction = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_BEQ:  encode_instruction = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                                     imm[4:1], imm[11], OPC_BRANCH};
      default: encode_instruction = NOP_INSTRUCTION;
    endcase
  endfunction

endpackage

// File: rtl/program_encoder_sync_fifo.sv
// Single-clock FIFO with occupancy count; depth must be a power of two.
module program_encoder_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/program_encoder.sv
// Streaming RV32I descriptor encoder that loads encoded words into
// instruction memory from word address 0 through a small FIFO.
module program_encoder
  import program_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instr_op_type          in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  enc_state_t            r_state;
  enc_state_t            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_error;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [31:0]           w_word;
  logic [31:0]           w_head;

  assign w_word    = encode_instruction(in_op, in_rd, in_rs1, in_rs2, in_imm);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = mem_we & mem_ready;

  assign in_ready  = (r_state == ST_LOAD) & ~w_full;
  assign mem_we    = ~w_empty;
  assign mem_wdata = w_empty ? 32'h0 : w_head;
  assign mem_addr  = r_addr;
  assign busy      = (r_state == ST_LOAD) | (r_state == ST_FLUSH);
  assign done      = (r_state == ST_DONE);
  assign error     = r_error;

  program_encoder_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FLUSH exits as the final write completes so done lands the cycle after it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_push && in_last) w_next = ST_FLUSH;
      ST_FLUSH: if (w_empty || (w_count == CW'(1) && w_pop)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_error <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_addr  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (r_addr == '1) r_error <= 1'b1;
      end
      if (w_push && !op_is_defined(in_op)) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Scoreboard bench for program_encoder: default instance plus a 2-bit address instance for wrap.
module tb_program_encoder;
  import program_encoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b1;
  instr_op_type in_op = OP_ADD;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, mem_we, busy, done, error;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;

  logic start_w = 1'b0, in_valid_w = 1'b0, in_last_w = 1'b0;
  instr_op_type in_op_w = OP_ADDI;
  logic [31:0] in_imm_w = '0;
  logic in_ready_w, mem_we_w, busy_w, done_w, error_w;
  logic [1:0] mem_addr_w;
  logic [31:0] mem_wdata_w;

  program_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .error(error)
  );

  program_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_op(in_op_w), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(in_imm_w),
    .in_last(in_last_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
    .mem_ready(1'b1), .busy(busy_w), .done(done_w), .error(error_w)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int wr_cnt = 0, wr_first = 0, wr_last = 0;
  logic [31:0] q_data[$];
  logic [9:0]  q_addr[$];
  logic [31:0] qw_data[$];
  logic [1:0]  qw_addr[$];
  logic [9:0]  exp_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the main instance: every completed write must match the queue head.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      if (wr_cnt == 0) wr_first = cyc;
      wr_last = cyc;
      wr_cnt++;
      n_vec++;
      if (q_data.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: addr=%0d data=%h, none expected", mem_addr, mem_wdata);
      end else begin
        logic [31:0] ed; logic [9:0] ea;
        ed = q_data.pop_front(); ea = q_addr.pop_front();
        if (mem_wdata !== ed || mem_addr !== ea) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, ea, ed);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_we_w) begin
      n_vec++;
      if (qw_data.size() == 0) begin
        n_err++;
        $display("FAIL wrap_write_unexpected: addr=%0d data=%h", mem_addr_w, mem_wdata_w);
      end else begin
        logic [31:0] ed; logic [1:0] ea;
        ed = qw_data.pop_front(); ea = qw_addr.pop_front();
        if (mem_wdata_w !== ed || mem_addr_w !== ea) begin
          n_err++;
          $display("FAIL wrap_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr_w, mem_wdata_w, ea, ed);
        end
      end
    end
  end

  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = '0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start: busy=%b in_ready=%b, expected 1 1", busy, in_ready);
    end
  endtask

  task automatic send(input instr_op_type op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        q_data.push_back(exp); q_addr.push_back(exp_addr);
        exp_addr = exp_addr + 10'd1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic wait_done(input string name);
    int pulses, dcyc;
    pulses = 0; dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (dcyc < 0) dcyc = cyc;
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s_busy_in_done: busy=%b, expected 0", name, busy);
        end
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d, expected 1", name, pulses);
    end
    n_vec++;
    if (dcyc != wr_last + 1) begin
      n_err++;
      $display("FAIL %s_done_timing: done cycle %0d, expected %0d", name, dcyc, wr_last + 1);
    end
    n_vec++;
    if (q_data.size() != 0) begin
      n_err++;
      $display("FAIL %s_words_left: %0d words not written, expected 0", name, q_data.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({in_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset: rdy=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h, expected all 0",
               in_ready, mem_we, busy, done, error, mem_addr, mem_wdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    start_session();
    wr_cnt = 0;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3);
    wait_done("add");
    start_session();
    send(OP_SUB, 5'd5, 5'd6, 5'd7, 32'h0, 1'b1, 32'h407302B3);
    wait_done("sub");
    n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_done: in_ready=%b busy=%b, expected 0 0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    start_session();
    wr_cnt = 0;
    mem_ready = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00093);
    send(OP_LUI,  5'd2, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h12345137);
    send(OP_SRAI, 5'd4, 5'd4, 5'd0, 32'd3,         1'b0, 32'h40325213);
    send(OP_SW,   5'd0, 5'd1, 5'd2, 32'd8,         1'b0, 32'h0020A423);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE208EE3);
    wait_done("stream");
    n_vec++;
    if (wr_cnt != 5 || wr_last - wr_first != 4) begin
      n_err++;
      $display("FAIL stream_throughput: %0d writes over %0d cycles, expected 5 over 5",
               wr_cnt, wr_last - wr_first + 1);
    end
  endtask

  task automatic test_backpressure();
    instr_op_type ops[6] = '{OP_ADD, OP_XOR, OP_ORI, OP_LW, OP_SLL, OP_AND};
    logic [4:0]  rds[6]  = '{5'd1, 5'd4, 5'd7, 5'd9, 5'd11, 5'd14};
    logic [4:0]  r1s[6]  = '{5'd2, 5'd5, 5'd8, 5'd10, 5'd12, 5'd15};
    logic [4:0]  r2s[6]  = '{5'd3, 5'd6, 5'd0, 5'd0, 5'd13, 5'd16};
    logic [31:0] ims[6]  = '{32'h0, 32'h0, 32'h0F0, 32'd16, 32'h0, 32'h0};
    logic [31:0] exps[6] = '{32'h003100B3, 32'h0062C233, 32'h0F046393,
                             32'h01052483, 32'h00D615B3, 32'h0107F733};
    int idx, stall_bad;
    start_session();
    wr_cnt = 0;
    mem_ready = 1'b0;
    idx = 0; stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_op = ops[idx]; in_rd = rds[idx]; in_rs1 = r1s[idx];
      in_rs2 = r2s[idx]; in_imm = ims[idx]; in_last = (idx == 5);
      @(negedge clk);
      if (mem_we && (mem_addr !== 10'd0 || mem_wdata !== exps[0])) stall_bad++;
      if (in_ready) begin
        q_data.push_back(exps[idx]); q_addr.push_back(exp_addr);
        exp_addr = exp_addr + 10'd1; idx++;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (idx != 4 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accepts: %0d accepted, in_ready=%b, expected 4 and 0", idx, in_ready);
    end
    n_vec++;
    if (stall_bad != 0 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, mem_we=%b, expected 0 and 1", stall_bad, mem_we);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      in_valid = 1'b1; in_op = ops[idx]; in_rd = rds[idx]; in_rs1 = r1s[idx];
      in_rs2 = r2s[idx]; in_imm = ims[idx]; in_last = (idx == 5);
      @(negedge clk);
      if (in_ready) begin
        q_data.push_back(exps[idx]); q_addr.push_back(exp_addr);
        exp_addr = exp_addr + 10'd1; idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("bp");
    n_vec++;
    if (wr_cnt != 6) begin
      n_err++;
      $display("FAIL bp_count: %0d writes, expected 6", wr_cnt);
    end
  endtask

  task automatic test_illegal();
    start_session();
    send(instr_op_type'(5'd31), 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h00000013);
    wait_done("illegal");
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (error !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_sticky: error=%b, expected 1", error);
    end
    start_session();
    n_vec++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL error_clear: error=%b, expected 0", error);
    end
    send(OP_ANDI, 5'd1, 5'd1, 5'd0, 32'h0FF, 1'b1, 32'h0FF0F093);
    wait_done("andi");
    n_vec++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL legal_no_error: error=%b, expected 0", error);
    end
  endtask

  task automatic test_wrap();
    int acc;
    acc = 0;
    start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    for (int k = 0; k < 40 && acc < 5; k++) begin
      in_valid_w = 1'b1; in_op_w = OP_ADDI; in_imm_w = 32'(acc + 1); in_last_w = (acc == 4);
      @(negedge clk);
      if (in_ready_w) begin
        qw_data.push_back(32'h93 | (32'(acc + 1) << 20));
        qw_addr.push_back(2'(acc));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid_w = 1'b0; in_last_w = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (acc != 5 || qw_data.size() != 0 || error_w !== 1'b1 || busy_w !== 1'b0) begin
      n_err++;
      $display("FAIL wrap: accepted=%0d left=%0d error=%b busy=%b, expected 5 0 1 0",
               acc, qw_data.size(), error_w, busy_w);
    end
  endtask

  task automatic test_reset_flush();
    int late_we;
    start_session();
    mem_ready = 1'b0;
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h003100B3);
    send(OP_XOR, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 32'h0062C233);
    send(OP_AND, 5'd14, 5'd15, 5'd16, 32'h0, 1'b1, 32'h0107F733);
    n_vec++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state: busy=%b we=%b rdy=%b, expected 1 1 0", busy, mem_we, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    q_data.delete(); q_addr.delete();
    n_vec++;
    if ({in_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_flush: rdy=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h, expected all 0",
               in_ready, mem_we, busy, done, error, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    late_we = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_we) late_we++;
    end
    n_vec++;
    if (late_we != 0) begin
      n_err++;
      $display("FAIL post_reset_we: %0d write cycles, expected 0", late_we);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
